menu_nav_fsm: RTL and testbench
===============================

Name: menu_nav_fsm

Overview:
- Parametrised menu-navigation controller for the game-select screen; generalises the fixed four-entry menu to NUM_ITEMS entries.
- Takes debounced button levels (Button outputs) and converts them to press events, with optional hold-to-repeat on up/down.
- Keeps the cursor, the enter/return state and the terminal-exit lock. Feeds the VGA menu renderer and per-game start/stop logic.

Parameters:
- NUM_ITEMS, 4, number of menu entries (>=2); the last entry is the exit item when LOCK_LAST=1.
- IDX_W, 2, cursor width; must satisfy 2**IDX_W >= NUM_ITEMS.
- LOCK_LAST, 1, 1: entering the last item locks the FSM until reset; 0: the last item behaves like a game.
- RETURN_HOME, 0, 1: on return, cursor goes to 0; 0: cursor stays on the entered item.
- ALLOW_BACK, 1, 1: btn_left while in a game forces a return to the menu.
- REPEAT_DELAY, 50000000, number of held cycles before the first auto-repeat step; 0 disables auto-repeat.
- REPEAT_RATE, 10000000, number of cycles between subsequent auto-repeat steps (>=1).

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  reset; asynchronous, active-high (asserted = 1) despite the name.
- btn_up  in  1  debounced level.
- btn_down  in  1  debounced level.
- btn_left  in  1  debounced level.
- btn_right  in  1  debounced level; acts as select/confirm.
- game_done  in  1  level/pulse from the active game; requests a return to the menu.
- cursor  out  IDX_W  highlighted or active entry index.
- in_game  out  1  high while an entry other than a locked exit is active.
- locked  out  1  high in the LOCK state.
- enter_pulse  out  1  one-cycle pulse on entry to IN.
- return_pulse  out  1  one-cycle pulse on a return from IN to MENU.
- state_output  out  2  debug encoding: 0=MENU, 1=IN, 2=LOCK.

Behaviour:
- Reset (async, sys_rst_n=1):
  - State = MENU, cursor = 0.
  - in_game, locked, enter_pulse, return_pulse = 0.
  - Edge and repeat registers cleared; button history = 0, so a button held through reset release produces a press.
- Press detection: press_x = btn_x & ~btn_x_q, where btn_x_q is the level registered at the previous edge.
- Auto-repeat (up/down only, REPEAT_DELAY>0):
  - The held counter starts on press and clears when the button is released or the other direction is pressed.
  - A repeat step fires when the count reaches REPEAT_DELAY, then every REPEAT_RATE cycles.
  - A step is treated exactly like a press.
- Registered outputs: every output changes at the sys_clk edge where the triggering event is evaluated, so it is visible one cycle after the qualifying level.
- MENU state, priority down > up > right (simultaneous events resolve by this order, one action per cycle):
  - down: cursor = (cursor==NUM_ITEMS-1) ? 0 : cursor+1.
  - up: cursor = (cursor==0) ? NUM_ITEMS-1 : cursor-1.
  - right, cursor==NUM_ITEMS-1 and LOCK_LAST=1: state = LOCK, locked = 1.
  - right, any other entry: state = IN, in_game = 1, enter_pulse = 1 for one cycle.
  - left in MENU: ignored.
- IN state:
  - cursor frozen; up/down/right ignored; repeat counters held at 0.
  - Return when game_done=1, or when ALLOW_BACK=1 and press_left.
  - On return: state = MENU, in_game = 0, return_pulse = 1; cursor = 0 if RETURN_HOME else unchanged.
  - A button press in the same cycle as the return is not acted on in MENU. Any button still held after return needs a new rising edge.
- LOCK state: absorbing; all inputs ignored; only reset leaves it. cursor = NUM_ITEMS-1.
- game_done while in MENU or LOCK: ignored.
- Reset mid-operation: any state returns to MENU with cursor 0 asynchronously; pending pulses are dropped.
- cursor is never >= NUM_ITEMS, for non-power-of-two NUM_ITEMS as well.

Test Plan:
- NUM_ITEMS=4, reset, then down×3 then down → cursor 1,2,3,0; up from 0 → 3 (wrap in both directions).
- down and up rise in the same cycle at cursor=1 → cursor=2. btn_down held 3 cycles → exactly one step.
- REPEAT_DELAY=8, REPEAT_RATE=4, down held 20 cycles from cursor 0 → steps at hold cycles 0, 8, 12, 16 → cursor 0→1→2→3→0.
- Cursor 2, right → in_game=1, enter_pulse for 1 cycle; down ignored. Then game_done → return_pulse, cursor=2 (RETURN_HOME=0). Repeat with RETURN_HOME=1 → cursor=0.
- Cursor 3, right with LOCK_LAST=1 → locked=1, state_output=2; right/left/game_done ignored. sys_rst_n pulse → MENU, cursor 0, locked 0.
- NUM_ITEMS=5, IDX_W=3, ALLOW_BACK=1: enter item 4 (not locked when LOCK_LAST=0), left → return; down from 4 → 0, cursor never reaches 5–7.

Source files
------------

// File: rtl/menu_nav_fsm.sv
// Menu-navigation controller for the game-select screen.
// Turns debounced button levels into press events (with optional hold-to-repeat
// on up/down), moves the cursor, and tracks MENU / IN-game / LOCK state.
module menu_nav_fsm #(
  parameter int NUM_ITEMS    = 4,
  parameter int IDX_W        = 2,
  parameter bit LOCK_LAST    = 1'b1,
  parameter bit RETURN_HOME  = 1'b0,
  parameter bit ALLOW_BACK   = 1'b1,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,     // active-high despite the name
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             game_done,
  output logic [IDX_W-1:0] cursor,
  output logic             in_game,
  output logic             locked,
  output logic             enter_pulse,
  output logic             return_pulse,
  output logic [1:0]       state_output
);

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_IN   = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic             enter_q, enter_d;
  logic             return_q, return_d;

  // Button history: level seen at the previous edge, for rising-edge detection.
  logic up_q, down_q, left_q, right_q;

  // Auto-repeat tracker: one direction at a time (dir 1 = down, 0 = up).
  // phase 0 waits REPEAT_DELAY held cycles, phase 1 steps every REPEAT_RATE.
  logic             rep_active_q, rep_active_d;
  logic             rep_dir_q, rep_dir_d;
  logic             rep_phase_q, rep_phase_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_step;

  logic press_up, press_down, press_left, press_right;
  logic step_up, step_down, held_btn;

  assign press_up    = btn_up    & ~up_q;
  assign press_down  = btn_down  & ~down_q;
  assign press_left  = btn_left  & ~left_q;
  assign press_right = btn_right & ~right_q;

  // Hold-to-repeat bookkeeping; only runs while the menu is shown.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rep_active_d = rep_active_q;
    rep_dir_d    = rep_dir_q;
    rep_phase_d  = rep_phase_q;
    rep_cnt_d    = rep_cnt_q;
    rep_step     = 1'b0;
    held_btn     = rep_dir_q ? btn_down : btn_up;
    if (state_q != ST_MENU || REPEAT_DELAY == 0) begin
      rep_active_d = 1'b0;
      rep_phase_d  = 1'b0;
      rep_cnt_d    = '0;
    end else if (press_down || press_up) begin
      // A fresh press (re)starts tracking; down wins a simultaneous press.
      rep_active_d = 1'b1;
      rep_dir_d    = press_down;
      rep_phase_d  = 1'b0;
      rep_cnt_d    = CNT_W'(1);
    end else if (rep_active_q && !held_btn) begin
      rep_active_d = 1'b0;
      rep_phase_d  = 1'b0;
      rep_cnt_d    = '0;
    end else if (rep_active_q) begin
      if (rep_cnt_q == (rep_phase_q ? RATE_C : DELAY_C)) begin
        rep_step    = 1'b1;
        rep_phase_d = 1'b1;
        rep_cnt_d   = CNT_W'(1);
      end else begin
        rep_cnt_d = rep_cnt_q + CNT_W'(1);
      end
    end
  end

  assign step_down = press_down | (rep_step &  rep_dir_q);
  assign step_up   = press_up   | (rep_step & ~rep_dir_q);

  // Next-state, cursor and pulse logic; one action per cycle, down > up > right.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    enter_d  = 1'b0;
    return_d = 1'b0;
    unique case (state_q)
      ST_MENU: begin
        if (step_down) begin
          cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + IDX_W'(1);
        end else if (step_up) begin
          cursor_d = (cursor_q == '0) ? LAST_IDX : cursor_q - IDX_W'(1);
        end else if (press_right) begin
          if (LOCK_LAST && cursor_q == LAST_IDX) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_IN;
            enter_d = 1'b1;
          end
        end
      end
      ST_IN: begin
        if (game_done || (ALLOW_BACK && press_left)) begin
          state_d  = ST_MENU;
          return_d = 1'b1;
          if (RETURN_HOME) cursor_d = '0;
        end
      end
      ST_LOCK: cursor_d = LAST_IDX;
      default: begin
        state_d  = ST_MENU;
        cursor_d = '0;
      end
    endcase
  end

  // State, outputs, button history and repeat tracker registers.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q      <= ST_MENU;
      cursor_q     <= '0;
      enter_q      <= 1'b0;
      return_q     <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      rep_active_q <= 1'b0;
      rep_dir_q    <= 1'b0;
      rep_phase_q  <= 1'b0;
      rep_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      enter_q      <= enter_d;
      return_q     <= return_d;
      up_q         <= btn_up;
      down_q       <= btn_down;
      left_q       <= btn_left;
      right_q      <= btn_right;
      rep_active_q <= rep_active_d;
      rep_dir_q    <= rep_dir_d;
      rep_phase_q  <= rep_phase_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

  assign cursor       = cursor_q;
  assign in_game      = (state_q == ST_IN);
  assign locked       = (state_q == ST_LOCK);
  assign enter_pulse  = enter_q;
  assign return_pulse = return_q;
  assign state_output = state_q;

endmodule

// File: tb/tb_menu_nav_fsm.sv
// Bench for menu_nav_fsm: two configurations driven by the same buttons,
// a vector table, hand sequences for multi-cycle corners, and a randomized
// run against an arithmetic reference model.
module tb_menu_nav_fsm;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic btn_up, btn_down, btn_left, btn_right, game_done;

  logic [1:0] cur_a;
  logic [2:0] cur_b;
  logic       ig_a, lk_a, en_a, rt_a, ig_b, lk_b, en_b, rt_b;
  logic [1:0] st_a, st_b;

  always #5 sys_clk = ~sys_clk;

  // Config A: four items, exit locks, cursor stays on return, fast repeat.
  menu_nav_fsm #(
    .NUM_ITEMS(4), .IDX_W(2), .LOCK_LAST(1'b1), .RETURN_HOME(1'b0),
    .ALLOW_BACK(1'b1), .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .game_done(game_done),
    .cursor(cur_a), .in_game(ig_a), .locked(lk_a),
    .enter_pulse(en_a), .return_pulse(rt_a), .state_output(st_a)
  );

  // Config B: five items, no lock, cursor homes on return.
  menu_nav_fsm #(
    .NUM_ITEMS(5), .IDX_W(3), .LOCK_LAST(1'b0), .RETURN_HOME(1'b1),
    .ALLOW_BACK(1'b1), .REPEAT_DELAY(3), .REPEAT_RATE(2)
  ) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .game_done(game_done),
    .cursor(cur_b), .in_game(ig_b), .locked(lk_b),
    .enter_pulse(en_b), .return_pulse(rt_b), .state_output(st_b)
  );

  typedef struct {
    int n;
    bit lock_last;
    bit ret_home;
    bit allow_back;
    int delay;
    int rate;
  } cfg_t;

  cfg_t cfg [2];

  // Reference model state (mode: 0 menu, 1 in game, 2 locked).
  int m_mode [2];
  int m_cur  [2];
  bit m_en   [2];
  bit m_ret  [2];
  bit m_up [2], m_dn [2], m_lf [2], m_rt [2];
  int m_track [2];   // 0 none, 1 down, 2 up
  int m_k     [2];   // cycles since the tracked press

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [4:0] Z = 5'b00000, U = 5'b10000, D = 5'b01000,
                         L = 5'b00100, R = 5'b00010, G = 5'b00001;

  typedef struct {
    logic [4:0] in;
    int cur;
    int st;
    bit en;
    bit ret;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] pack(input int mode, input int cur, input bit en, input bit ret);
    return {2'(mode), (mode == 1), (mode == 2), en, ret, 2'b00, 8'(cur)};
  endfunction

  function automatic logic [15:0] act_a();
    return {st_a, ig_a, lk_a, en_a, rt_a, 2'b00, 8'(cur_a)};
  endfunction

  function automatic logic [15:0] act_b();
    return {st_b, ig_b, lk_b, en_b, rt_b, 2'b00, 8'(cur_b)};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_cur[d] = 0; m_en[d] = 0; m_ret[d] = 0;
      m_up[d] = 0; m_dn[d] = 0; m_lf[d] = 0; m_rt[d] = 0;
      m_track[d] = 0; m_k[d] = 0;
    end
  endtask

  // One clock edge of the behavioural model for configuration d.
  task automatic model_step(input int d, input logic [4:0] in);
    bit up, dn, lf, rt, gd, pu, pd, pl, pr, su, sd;
    {up, dn, lf, rt, gd} = in;
    pu = up & ~m_up[d]; pd = dn & ~m_dn[d];
    pl = lf & ~m_lf[d]; pr = rt & ~m_rt[d];
    su = 0; sd = 0;
    if (m_mode[d] != 0) m_track[d] = 0;
    else if (pd) begin m_track[d] = 1; m_k[d] = 0; sd = 1; end
    else if (pu) begin m_track[d] = 2; m_k[d] = 0; su = 1; end
    else if (m_track[d] != 0 && !((m_track[d] == 1) ? dn : up)) m_track[d] = 0;
    else if (m_track[d] != 0) begin
      m_k[d]++;
      if (cfg[d].delay > 0 && m_k[d] >= cfg[d].delay &&
          (m_k[d] - cfg[d].delay) % cfg[d].rate == 0) begin
        if (m_track[d] == 1) sd = 1; else su = 1;
      end
    end
    m_en[d] = 0; m_ret[d] = 0;
    case (m_mode[d])
      0: begin
        if (sd) m_cur[d] = (m_cur[d] + 1) % cfg[d].n;
        else if (su) m_cur[d] = (m_cur[d] + cfg[d].n - 1) % cfg[d].n;
        else if (pr) begin
          if (cfg[d].lock_last && m_cur[d] == cfg[d].n - 1) m_mode[d] = 2;
          else begin m_mode[d] = 1; m_en[d] = 1; end
        end
      end
      1: if (gd || (cfg[d].allow_back && pl)) begin
        m_mode[d] = 0; m_ret[d] = 1;
        if (cfg[d].ret_home) m_cur[d] = 0;
      end
      default: ;
    endcase
    m_up[d] = up; m_dn[d] = dn; m_lf[d] = lf; m_rt[d] = rt;
  endtask

  // Drive inputs (from a negedge), clock once, check both DUTs against the model.
  task automatic step(input logic [4:0] in, input bit rst, input string tag);
    {btn_up, btn_down, btn_left, btn_right, game_done} = in;
    sys_rst_n = rst;
    @(posedge sys_clk);
    if (rst) model_reset();
    else begin
      model_step(0, in);
      model_step(1, in);
    end
    #1;
    check({tag, " model a"}, act_a(), pack(m_mode[0], m_cur[0], m_en[0], m_ret[0]));
    check({tag, " model b"}, act_b(), pack(m_mode[1], m_cur[1], m_en[1], m_ret[1]));
    @(negedge sys_clk);
  endtask

  task automatic add(input logic [4:0] in, input int cur, input int st, input bit en, input bit ret);
    vec_t v;
    v.in = in; v.cur = cur; v.st = st; v.en = en; v.ret = ret;
    tbl.push_back(v);
  endtask

  initial begin
    logic [4:0] lvl;
    cfg[0] = '{n: 4, lock_last: 1, ret_home: 0, allow_back: 1, delay: 8, rate: 4};
    cfg[1] = '{n: 5, lock_last: 0, ret_home: 1, allow_back: 1, delay: 3, rate: 2};

    // Expected outputs of config A after each edge.
    add(D, 1, 0, 0, 0); add(Z, 1, 0, 0, 0);
    add(D, 2, 0, 0, 0); add(Z, 2, 0, 0, 0);
    add(D, 3, 0, 0, 0); add(Z, 3, 0, 0, 0);
    add(D, 0, 0, 0, 0); add(Z, 0, 0, 0, 0);   // wrap down
    add(U, 3, 0, 0, 0); add(Z, 3, 0, 0, 0);   // wrap up
    add(U, 2, 0, 0, 0); add(Z, 2, 0, 0, 0);
    add(U, 1, 0, 0, 0); add(Z, 1, 0, 0, 0);
    add(U | D, 2, 0, 0, 0); add(Z, 2, 0, 0, 0); // down beats up
    add(D, 3, 0, 0, 0); add(D, 3, 0, 0, 0); add(D, 3, 0, 0, 0); // held 3 cycles
    add(Z, 3, 0, 0, 0);
    add(U, 2, 0, 0, 0); add(Z, 2, 0, 0, 0);
    add(R, 2, 1, 1, 0); add(Z, 2, 1, 0, 0);   // enter item 2
    add(D, 2, 1, 0, 0); add(Z, 2, 1, 0, 0);   // down ignored in game
    add(G, 2, 0, 0, 1); add(Z, 2, 0, 0, 0);   // game_done returns
    add(L, 2, 0, 0, 0); add(Z, 2, 0, 0, 0);   // left ignored in menu
    add(R, 2, 1, 1, 0); add(Z, 2, 1, 0, 0);
    add(L, 2, 0, 0, 1); add(Z, 2, 0, 0, 0);   // back button returns
    add(D, 3, 0, 0, 0); add(Z, 3, 0, 0, 0);
    add(R, 3, 2, 0, 0); add(Z, 3, 2, 0, 0);   // exit item locks
    add(R, 3, 2, 0, 0); add(L, 3, 2, 0, 0);
    add(G, 3, 2, 0, 0); add(D, 3, 2, 0, 0); add(Z, 3, 2, 0, 0);

    {btn_up, btn_down, btn_left, btn_right, game_done} = '0;
    sys_rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge sys_clk);
    check("reset a", act_a(), 16'h0000);
    check("reset b", act_b(), 16'h0000);
    sys_rst_n = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].in, 1'b0, $sformatf("tbl[%0d]", i));
      check($sformatf("tbl[%0d] vec", i), act_a(),
            pack(tbl[i].st, tbl[i].cur, tbl[i].en, tbl[i].ret));
    end

    // Asynchronous reset out of LOCK, with down held through release.
    #2;
    btn_down  = 1'b1;
    sys_rst_n = 1'b1;
    #1;
    check("async reset a", act_a(), 16'h0000);
    check("async reset b", act_b(), 16'h0000);
    @(negedge sys_clk);
    model_reset();
    step(D, 1'b0, "held through reset");
    check("held through reset a", act_a(), pack(0, 1, 0, 0));
    step(Z, 1'b1, "reset again");

    // Auto-repeat: down held 20 cycles from cursor 0, steps at hold cycles 0,8,12,16.
    step(Z, 1'b0, "idle");
    for (int k = 0; k < 20; k++) begin
      int exp_cur;
      exp_cur = (k < 8) ? 1 : (k < 12) ? 2 : (k < 16) ? 3 : 0;
      step(D, 1'b0, $sformatf("repeat k%0d", k));
      check($sformatf("repeat k%0d a", k), act_a(), pack(0, exp_cur, 0, 0));
    end
    step(Z, 1'b0, "repeat release");

    // Five-item menu: enter the last item without locking, back out, wrap down.
    step(Z, 1'b1, "reset b seq");
    step(Z, 1'b0, "idle b");
    step(U, 1'b0, "b up wrap");
    check("b up wrap to 4", act_b(), pack(0, 4, 0, 0));
    step(Z, 1'b0, "b idle");
    step(R, 1'b0, "b enter 4");
    check("b enter 4", act_b(), pack(1, 4, 1, 0));
    step(Z, 1'b0, "b in game");
    step(L, 1'b0, "b back");
    check("b back home", act_b(), pack(0, 0, 0, 1));
    step(Z, 1'b0, "b idle2");
    step(U, 1'b0, "b up again");
    step(Z, 1'b0, "b idle3");
    step(D, 1'b0, "b down wrap");
    check("b down 4 to 0", act_b(), pack(0, 0, 0, 0));

    // Randomized run against the model.
    step(Z, 1'b1, "reset rand");
    lvl = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) lvl[4] = ~lvl[4];
      if ($urandom_range(5) == 0) lvl[3] = ~lvl[3];
      if ($urandom_range(3) == 0) lvl[2] = ~lvl[2];
      if ($urandom_range(3) == 0) lvl[1] = ~lvl[1];
      lvl[0] = ($urandom_range(11) == 0);
      step(lvl, ($urandom_range(149) == 0), $sformatf("rand c%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
